// File: rtl/riscv_reg_file.sv
// RV32I integer register file: 32 x XLEN, two combinational read ports, one write port.
// x0 reads as zero; optional same-cycle write-to-read bypass for the decode stage.
module riscv_reg_file #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned ADDR_W = $clog2(NREG),
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [ADDR_W-1:0] adr2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   wd,
  output logic [XLEN-1:0]   rs1,
  output logic [XLEN-1:0]   rs2
);

  // x0 has no storage; the array starts at index 1.
  logic [XLEN-1:0] regs_q [1:NREG-1];

  logic wr_en_c;
  logic byp1_c;
  logic byp2_c;

  // A write only lands outside reset and never to x0.
  assign wr_en_c = !reset && we && (rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else if (wr_en_c) begin
      regs_q[rd] <= wd;
    end
  end

  assign byp1_c = (BYPASS != 0) && wr_en_c && (rd == adr1);
  assign byp2_c = (BYPASS != 0) && wr_en_c && (rd == adr2);

  // Bypassed write data takes priority over the stored value.
  always_comb begin
    rs1 = '0;
    rs2 = '0;
    if (adr1 != '0) rs1 = regs_q[adr1];
    if (adr2 != '0) rs2 = regs_q[adr2];
    if (byp1_c) rs1 = wd;
    if (byp2_c) rs2 = wd;
  end

endmodule

// File: tb/tb_riscv_reg_file.sv
// Bench for riscv_reg_file: directed vectors plus a random run against a reference model.
// A second instance with forwarding disabled shares all inputs.
module tb_riscv_reg_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  adr1;
  logic [4:0]  adr2;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] nb_rs1;
  logic [31:0] nb_rs2;

  int unsigned tests_run;
  int unsigned tests_failed;
  logic [31:0] model [32];

  riscv_reg_file #(.XLEN(32), .NREG(32), .ADDR_W(5), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .we(we), .adr1(adr1), .adr2(adr2),
    .rd(rd), .wd(wd), .rs1(rs1), .rs2(rs2)
  );

  riscv_reg_file #(.XLEN(32), .NREG(32), .ADDR_W(5), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .we(we), .adr1(adr1), .adr2(adr2),
    .rd(rd), .wd(wd), .rs1(nb_rs1), .rs2(nb_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Advance one edge, mirror the architectural update in the model, settle off the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && rd != 5'd0) begin
      model[rd] = wd;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] e1;
    logic [31:0] e2;
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    reset = 1'b1; we = 1'b0; adr1 = '0; adr2 = '0; rd = '0; wd = '0;
    tick();
    reset = 1'b0;

    // Reset state
    adr1 = 5'd5; adr2 = 5'd31; #1;
    check("reset_rs1_x5", rs1, 32'h0);
    check("reset_rs2_x31", rs2, 32'h0);

    // Reset wins over a simultaneous write and disables the bypass
    write_reg(5'd5, 32'hDEADBEEF);
    adr1 = 5'd5; adr2 = 5'd7; #1;
    check("pre_reset_x5", rs1, 32'hDEADBEEF);
    reset = 1'b1; we = 1'b1; rd = 5'd7; wd = 32'hCAFEF00D; #1;
    check("reset_no_bypass_x7", rs2, 32'h0);
    check("reset_stored_x5", rs1, 32'hDEADBEEF);
    tick();
    reset = 1'b0; we = 1'b0; #1;
    check("post_reset_x5", rs1, 32'h0);
    check("post_reset_x7", rs2, 32'h0);

    // x0 is hardwired
    we = 1'b1; rd = 5'd0; wd = 32'hFFFFFFFF; adr1 = 5'd0; adr2 = 5'd0; #1;
    check("x0_no_bypass_rs2", rs2, 32'h0);
    tick();
    we = 1'b0; #1;
    check("x0_after_write_rs1", rs1, 32'h0);

    // Write/read on both ports
    write_reg(5'd1, 32'h12345678);
    write_reg(5'd31, 32'h80000001);
    adr1 = 5'd1; adr2 = 5'd31; #1;
    check("rd_x1", rs1, 32'h12345678);
    check("rd_x31", rs2, 32'h80000001);
    adr1 = 5'd31; #1;
    check("same_adr_rs1", rs1, 32'h80000001);
    check("same_adr_rs2", rs2, 32'h80000001);

    // Bypass vs stored data
    write_reg(5'd3, 32'h11);
    we = 1'b1; rd = 5'd3; wd = 32'h22; adr1 = 5'd3; adr2 = 5'd3; #1;
    check("byp_rs1", rs1, 32'h22);
    check("byp_rs2", rs2, 32'h22);
    check("nobyp_rs1", nb_rs1, 32'h11);
    check("nobyp_rs2", nb_rs2, 32'h11);
    tick();
    we = 1'b0; #1;
    check("byp_after_rs1", rs1, 32'h22);
    check("byp_after_rs2", rs2, 32'h22);
    check("nobyp_after_rs1", nb_rs1, 32'h22);

    // we=0 holds state
    we = 1'b0; rd = 5'd9; wd = 32'hAAAA5555; adr1 = 5'd9; adr2 = 5'd1;
    repeat (3) tick();
    check("hold_x9", rs1, 32'h0);
    check("hold_x1", rs2, 32'h12345678);
    check("hold_x9_nb", nb_rs1, 32'h0);

    // Random traffic against the model, with forced address collisions
    for (int n = 0; n < 1000; n++) begin
      we   = 1'($urandom_range(0, 1));
      rd   = 5'($urandom_range(0, 31));
      wd   = $urandom();
      adr1 = 5'($urandom_range(0, 31));
      adr2 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) adr1 = rd;
      if ($urandom_range(0, 3) == 0) adr2 = rd;
      if ($urandom_range(0, 15) == 0) rd = 5'd0;
      #1;
      e1 = (adr1 == 5'd0) ? 32'h0 : model[adr1];
      e2 = (adr2 == 5'd0) ? 32'h0 : model[adr2];
      check("rand_nb_rs1", nb_rs1, e1);
      check("rand_nb_rs2", nb_rs2, e2);
      if (we && rd != 5'd0 && rd == adr1) e1 = wd;
      if (we && rd != 5'd0 && rd == adr2) e2 = wd;
      check("rand_rs1", rs1, e1);
      check("rand_rs2", rs2, e2);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
